ascii_sym_enc: RTL and testbench
================================

Name: ascii_sym_enc

Overview:
- Upstream front end of the dau. Takes raw ASCII bytes from the UART receiver and translates them into dau symbols.
- Removes redundant separators and buffers symbols in a small FIFO.
- Presents the symbols to the dau with a valid/ready handshake, so keystrokes typed while the dau is busy (MUL/DIV) are not lost.

Parameters:
- FIFO_DEPTH, 8: symbol FIFO entries. Power of two, at least 2.
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1: width of o_count.

Ports:
- i_clk, input, 1: system clock. Single clock domain.
- i_rst, input, 1: asynchronous, active-high reset.
- i_data, input, 8: ASCII byte from the UART receiver.
- i_data_valid, input, 1: one-cycle strobe; i_data is valid this cycle.
- i_ready, input, 1: dau o_ready.
- o_symbol, output, `DAU_SYM_WIDTH: symbol to dau i_symbol. Equals the FIFO head.
- o_valid, output, 1: to dau i_valid. High when the FIFO is non-empty.
- o_count, output, CNT_WIDTH: FIFO occupancy.
- o_overflow, output, 1: sticky. A symbol was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, deassert sampled on i_clk): o_valid=0, o_symbol=`DAU_SYM_INVALID, o_count=0, o_overflow=0, FIFO empty, last_was_sep=1, decode stage empty.
- Decode map (stage 1, registered):
  - '0'..'9' -> DAU_SYM_0..9
  - ',' and '.' -> COMMA
  - '-' -> MINUS; '+' -> PLUS; '*' and 'x' -> MUL; '/' -> DIV
  - ' ' and TAB -> SEPARATOR
  - '=' and CR (0x0D) -> RESULT
  - 'c', 'C' and ESC (0x1B) -> RESET
  - Any other byte (including LF) is discarded silently and changes no state.
- Separator filter:
  - A SEPARATOR is discarded when last_was_sep=1.
  - last_was_sep is set by SEPARATOR, RESULT and RESET, and cleared by every other accepted symbol.
  - Effect: leading and repeated spaces are collapsed.
- Latency:
  - Byte strobed in cycle k is decoded at edge k.
  - It is written to the FIFO at edge k+1.
  - With the FIFO empty, o_valid=1 and o_symbol valid from edge k+1.
  - Back-to-back strobes on consecutive cycles are supported: throughput is 1 byte/cycle.
- Handshake:
  - Pop occurs at a rising edge where o_valid && i_ready.
  - o_symbol holds stable while o_valid && !i_ready.
  - o_symbol = `DAU_SYM_INVALID whenever the FIFO is empty.
- FIFO:
  - Show-ahead; read and write pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle: both occur and o_count is unchanged. This holds when full as well: the pop frees the slot.
  - Push when full without a pop: the symbol is dropped, o_overflow=1, and last_was_sep is not updated.
- RESET symbol (priority path):
  - At its write edge, the FIFO is flushed and RESET becomes the only entry, so o_count=1.
  - o_overflow is cleared.
  - A pop in the same cycle is ignored: the flushed head is lost and RESET is delivered next.
- Reset mid-operation: i_rst asserted at any time returns to the reset state immediately. A byte in the decode stage is lost.
- The block never inspects dau internals. Backpressure comes only via i_ready.

Decomposition:
- Shared symbol include (the existing DAU_SYM_* defines): reuse `DAU_SYM_WIDTH and the symbol codes.
- Add ASCII constants there: ASCII_CR, ASCII_ESC, ASCII_TAB.
- One sub-module, sym_fifo (parameters WIDTH, DEPTH). It provides push, pop and flush_load (flush and write one entry), plus count, empty and full.
- ascii_sym_enc holds the decode register, the separator filter and the overflow flag.

Test Plan:
- Feed "-12,5 3+=" with i_ready=1 held -> symbols MINUS,1,2,COMMA,5,SEPARATOR,3,PLUS,RESULT. Each appears 2 cycles after its byte.
- Feed "  7   8 " (leading and multiple spaces) -> 7,SEPARATOR,8,SEPARATOR only. Bytes 'q' and LF -> no output, o_count unchanged.
- Hold i_ready=0 and feed 10 digit bytes with FIFO_DEPTH=8 -> o_count=8, o_overflow=1, o_symbol stays at the first digit. Release i_ready -> exactly the first 8 digits drain in order, one per cycle.
- With FIFO full and i_ready=1, strobe a byte in the same cycle as a pop -> o_count stays 8, no overflow, order preserved.
- FIFO holding 5 symbols, i_ready=0, feed 'C' -> after 2 cycles o_count=1, o_symbol=RESET, o_overflow=0. The next ' ' is discarded.
- Assert i_rst while the FIFO holds 3 entries and a byte is in decode -> next cycle o_valid=0, o_count=0, o_symbol=INVALID. A subsequent '4' yields 4 with the normal 2-cycle latency.

Source files
------------

// File: rtl/ascii_sym_enc_pkg.sv
// Shared dau symbol codes and ASCII constants, plus the byte-to-symbol decode table
// used by the ASCII front end of the dau.
`ifndef DAU_SYM_DEFS_SV
`define DAU_SYM_DEFS_SV
`define DAU_SYM_WIDTH     5
`define DAU_SYM_0         5'd0
`define DAU_SYM_1         5'd1
`define DAU_SYM_2         5'd2
`define DAU_SYM_3         5'd3
`define DAU_SYM_4         5'd4
`define DAU_SYM_5         5'd5
`define DAU_SYM_6         5'd6
`define DAU_SYM_7         5'd7
`define DAU_SYM_8         5'd8
`define DAU_SYM_9         5'd9
`define DAU_SYM_COMMA     5'd10
`define DAU_SYM_MINUS     5'd11
`define DAU_SYM_PLUS      5'd12
`define DAU_SYM_MUL       5'd13
`define DAU_SYM_DIV       5'd14
`define DAU_SYM_SEPARATOR 5'd15
`define DAU_SYM_RESULT    5'd16
`define DAU_SYM_RESET     5'd17
`define DAU_SYM_INVALID   5'd31
`define ASCII_CR          8'h0D
`define ASCII_ESC         8'h1B
`define ASCII_TAB         8'h09
`endif

package ascii_sym_enc_pkg;

   localparam int SYM_W = `DAU_SYM_WIDTH;
   typedef logic [SYM_W-1:0] sym_t;

   localparam sym_t SYM_0       = `DAU_SYM_0;
   localparam sym_t SYM_1       = `DAU_SYM_1;
   localparam sym_t SYM_2       = `DAU_SYM_2;
   localparam sym_t SYM_3       = `DAU_SYM_3;
   localparam sym_t SYM_4       = `DAU_SYM_4;
   localparam sym_t SYM_5       = `DAU_SYM_5;
   localparam sym_t SYM_6       = `DAU_SYM_6;
   localparam sym_t SYM_7       = `DAU_SYM_7;
   localparam sym_t SYM_8       = `DAU_SYM_8;
   localparam sym_t SYM_9       = `DAU_SYM_9;
   localparam sym_t SYM_COMMA   = `DAU_SYM_COMMA;
   localparam sym_t SYM_MINUS   = `DAU_SYM_MINUS;
   localparam sym_t SYM_PLUS    = `DAU_SYM_PLUS;
   localparam sym_t SYM_MUL     = `DAU_SYM_MUL;
   localparam sym_t SYM_DIV     = `DAU_SYM_DIV;
   localparam sym_t SYM_SEP     = `DAU_SYM_SEPARATOR;
   localparam sym_t SYM_RESULT  = `DAU_SYM_RESULT;
   localparam sym_t SYM_RESET   = `DAU_SYM_RESET;
   localparam sym_t SYM_INVALID = `DAU_SYM_INVALID;

   localparam logic [7:0] ASCII_CR  = `ASCII_CR;
   localparam logic [7:0] ASCII_ESC = `ASCII_ESC;
   localparam logic [7:0] ASCII_TAB = `ASCII_TAB;

   typedef struct packed {
      logic hit;
      sym_t sym;
   } dec_t;

   // hit=0 marks a byte that carries no meaning for the dau and must leave no trace
   function automatic dec_t ascii_decode(input logic [7:0] ch);
      dec_t d;
      d.hit = 1'b1;
      d.sym = SYM_INVALID;
      case (ch) inside
         [8'h30:8'h39]:               d.sym = SYM_0 + sym_t'(ch - 8'h30);
         8'h2C, 8'h2E:                d.sym = SYM_COMMA;
         8'h2D:                       d.sym = SYM_MINUS;
         8'h2B:                       d.sym = SYM_PLUS;
         8'h2A, 8'h78:                d.sym = SYM_MUL;
         8'h2F:                       d.sym = SYM_DIV;
         8'h20, ASCII_TAB:            d.sym = SYM_SEP;
         8'h3D, ASCII_CR:             d.sym = SYM_RESULT;
         8'h63, 8'h43, ASCII_ESC:     d.sym = SYM_RESET;
         default:                     d.hit = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/ascii_sym_enc_if.sv
// Symbol stream towards the dau: show-ahead symbol with valid/ready handshake.
interface ascii_sym_enc_if;
   import ascii_sym_enc_pkg::*;

   sym_t symbol;
   logic valid;
   logic ready;

   modport master (output symbol, output valid, input ready);
   modport slave  (input symbol, input valid, output ready);
endinterface

// File: rtl/sym_fifo.sv
// Show-ahead symbol FIFO with push, pop and a flush_load that empties it and
// leaves exactly one fresh entry.
module sym_fifo
   import ascii_sym_enc_pkg::*;
#(
   parameter int WIDTH = SYM_W,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush_load,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       push_ok
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic             pop_ok_s;
   logic             push_ok_s;
   logic             empty_s;
   logic             full_s;

   assign empty_s   = (count_r == CNT_W'(0));
   assign full_s    = (count_r == CNT_W'(DEPTH));
   assign pop_ok_s  = pop && !empty_s;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign push_ok_s = push && (!full_s || pop_ok_s);

   // occupancy update for the ordinary push/pop path
   always_comb begin
      count_nxt_s = count_r;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // storage, pointers and occupancy; flush_load overrides any push or pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush_load) begin
         mem_r[0] <= wr_data;
         rd_ptr_r <= '0;
         wr_ptr_r <= PTR_W'(1);
         count_r  <= CNT_W'(1);
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_nxt_s;
      end
   end

   assign head    = mem_r[rd_ptr_r];
   assign count   = count_r;
   assign empty   = empty_s;
   assign full    = full_s;
   assign push_ok = push_ok_s;

endmodule

// File: rtl/ascii_sym_enc.sv
// ASCII front end of the dau: decodes UART bytes into symbols, collapses redundant
// separators and queues the result so keystrokes survive while the dau is busy.
module ascii_sym_enc
   import ascii_sym_enc_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [7:0]           i_data,
   input  logic                 i_data_valid,
   ascii_sym_enc_if.master      sym_out,
   output logic [CNT_WIDTH-1:0] o_count,
   output logic                 o_overflow
);

   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

   dec_t              dec_s;
   logic              dec_valid_r;
   sym_t              dec_sym_r;
   logic              last_was_sep_r;
   logic              overflow_r;
   logic              is_reset_s;
   logic              sep_drop_s;
   logic              push_s;
   logic              pop_s;
   logic              push_ok_s;
   logic              empty_s;
   logic              full_s;
   sym_t              head_s;
   logic [FCNT_W-1:0] count_s;

   assign dec_s = ascii_decode(i_data);

   // decode stage; unmapped bytes simply leave the stage empty
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         dec_valid_r <= 1'b0;
         dec_sym_r   <= SYM_INVALID;
      end else if (i_data_valid) begin
         dec_valid_r <= dec_s.hit;
         dec_sym_r   <= dec_s.sym;
      end else begin
         dec_valid_r <= 1'b0;
      end
   end

   assign is_reset_s = dec_valid_r && (dec_sym_r == SYM_RESET);
   assign sep_drop_s = dec_valid_r && (dec_sym_r == SYM_SEP) && last_was_sep_r;
   assign push_s     = dec_valid_r && !is_reset_s && !sep_drop_s;
   assign pop_s      = sym_out.valid && sym_out.ready;

   // separator memory and sticky overflow; a dropped symbol must not move last_was_sep
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_was_sep_r <= 1'b1;
         overflow_r     <= 1'b0;
      end else if (is_reset_s) begin
         last_was_sep_r <= 1'b1;
         overflow_r     <= 1'b0;
      end else if (push_s) begin
         if (push_ok_s) begin
            last_was_sep_r <= (dec_sym_r == SYM_SEP) || (dec_sym_r == SYM_RESULT);
         end else begin
            overflow_r <= 1'b1;
         end
      end
   end

   sym_fifo #(
      .WIDTH (SYM_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (i_clk),
      .rst        (i_rst),
      .push       (push_s),
      .pop        (pop_s),
      .flush_load (is_reset_s),
      .wr_data    (dec_sym_r),
      .head       (head_s),
      .count      (count_s),
      .empty      (empty_s),
      .full       (full_s),
      .push_ok    (push_ok_s)
   );

   assign sym_out.valid  = !empty_s;
   assign sym_out.symbol = empty_s ? SYM_INVALID : head_s;
   assign o_count        = CNT_WIDTH'(count_s);
   assign o_overflow     = overflow_r;

endmodule

// File: tb/tb_ascii_sym_enc.sv
// Directed bench for ascii_sym_enc: inputs driven and outputs sampled on the falling edge.
module tb_ascii_sym_enc;
   import ascii_sym_enc_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [7:0] i_data = 8'h00;
   logic       i_data_valid = 1'b0;
   logic [3:0] o_count;
   logic       o_overflow;
   int         n_cmp = 0;
   int         n_bad = 0;

   ascii_sym_enc_if sym_if ();

   ascii_sym_enc #(.FIFO_DEPTH(8)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_data       (i_data),
      .i_data_valid (i_data_valid),
      .sym_out      (sym_if.master),
      .o_count      (o_count),
      .o_overflow   (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   sym_t digit_sym [10] = '{SYM_0, SYM_1, SYM_2, SYM_3, SYM_4, SYM_5, SYM_6, SYM_7, SYM_8, SYM_9};

   // strobe each byte on consecutive cycles; returns two edges after the last strobe
   task automatic feed(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge i_clk);
         i_data = s[i];
         i_data_valid = 1'b1;
      end
      @(negedge i_clk);
      i_data_valid = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_data_valid = 1'b0;
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (sym_if.valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", sym_if.valid); end
      n_cmp++; if (sym_if.symbol !== SYM_INVALID) begin n_bad++; $display("FAIL rst_symbol: got %0d want %0d", sym_if.symbol, SYM_INVALID); end
      n_cmp++; if (o_count !== 4'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", o_count); end
      n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b want 0", o_overflow); end
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_stream();
      string s = "-12,5 3+=";
      sym_t exp_q [9] = '{SYM_MINUS, SYM_1, SYM_2, SYM_COMMA, SYM_5, SYM_SEP, SYM_3, SYM_PLUS, SYM_RESULT};
      sym_if.ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge i_clk);
         if (i >= 2) begin
            n_cmp++; if (sym_if.valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i - 2, sym_if.valid); end
            n_cmp++; if (sym_if.symbol !== exp_q[i-2]) begin n_bad++; $display("FAIL stream_sym[%0d]: got %0d want %0d", i - 2, sym_if.symbol, exp_q[i-2]); end
         end
         if (i < 9) begin
            i_data = s[i];
            i_data_valid = 1'b1;
         end else begin
            i_data_valid = 1'b0;
         end
      end
      @(negedge i_clk);
      n_cmp++; if (sym_if.valid !== 1'b0) begin n_bad++; $display("FAIL stream_end_valid: got %b want 0", sym_if.valid); end
      sym_if.ready = 1'b0;
   endtask

   task automatic test_sep_filter();
      sym_t exp_q [4] = '{SYM_7, SYM_SEP, SYM_8, SYM_SEP};
      sym_if.ready = 1'b0;
      feed("  7   8 ");
      n_cmp++; if (o_count !== 4'd4) begin n_bad++; $display("FAIL sep_count: got %0d want 4", o_count); end
      feed("q\n");
      n_cmp++; if (o_count !== 4'd4) begin n_bad++; $display("FAIL ignore_count: got %0d want 4", o_count); end
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         sym_if.ready = 1'b1;
         n_cmp++; if (sym_if.symbol !== exp_q[i]) begin n_bad++; $display("FAIL sep_sym[%0d]: got %0d want %0d", i, sym_if.symbol, exp_q[i]); end
      end
      @(negedge i_clk);
      sym_if.ready = 1'b0;
      n_cmp++; if (sym_if.symbol !== SYM_INVALID) begin n_bad++; $display("FAIL sep_empty_sym: got %0d want %0d", sym_if.symbol, SYM_INVALID); end
   endtask

   task automatic test_overflow();
      sym_if.ready = 1'b0;
      feed("0123456789");
      n_cmp++; if (o_count !== 4'd8) begin n_bad++; $display("FAIL ovf_count: got %0d want 8", o_count); end
      n_cmp++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", o_overflow); end
      n_cmp++; if (sym_if.symbol !== SYM_0) begin n_bad++; $display("FAIL ovf_head: got %0d want %0d", sym_if.symbol, SYM_0); end
      for (int i = 0; i < 8; i++) begin
         @(negedge i_clk);
         sym_if.ready = 1'b1;
         n_cmp++; if (sym_if.valid !== 1'b1 || sym_if.symbol !== digit_sym[i]) begin n_bad++; $display("FAIL ovf_drain[%0d]: got %0d/%b want %0d/1", i, sym_if.symbol, sym_if.valid, digit_sym[i]); end
      end
      @(negedge i_clk);
      sym_if.ready = 1'b0;
      n_cmp++; if (sym_if.valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained_valid: got %b want 0", sym_if.valid); end
      n_cmp++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      sym_if.ready = 1'b0;
      feed("12345678");
      n_cmp++; if (o_count !== 4'd8) begin n_bad++; $display("FAIL full_count: got %0d want 8", o_count); end
      @(negedge i_clk);
      i_data = 8'h39;
      i_data_valid = 1'b1;
      @(negedge i_clk);
      i_data_valid = 1'b0;
      sym_if.ready = 1'b1;
      @(negedge i_clk);
      sym_if.ready = 1'b0;
      n_cmp++; if (o_count !== 4'd8) begin n_bad++; $display("FAIL pp_count: got %0d want 8", o_count); end
      n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL pp_overflow: got %b want 0", o_overflow); end
      for (int i = 0; i < 8; i++) begin
         @(negedge i_clk);
         sym_if.ready = 1'b1;
         n_cmp++; if (sym_if.symbol !== digit_sym[i+2]) begin n_bad++; $display("FAIL pp_drain[%0d]: got %0d want %0d", i, sym_if.symbol, digit_sym[i+2]); end
      end
      @(negedge i_clk);
      sym_if.ready = 1'b0;
      n_cmp++; if (o_count !== 4'd0) begin n_bad++; $display("FAIL pp_empty_count: got %0d want 0", o_count); end
   endtask

   task automatic test_reset_symbol();
      do_reset();
      sym_if.ready = 1'b0;
      feed("123456789");
      n_cmp++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL rs_pre_overflow: got %b want 1", o_overflow); end
      repeat (3) begin
         @(negedge i_clk);
         sym_if.ready = 1'b1;
      end
      @(negedge i_clk);
      sym_if.ready = 1'b0;
      n_cmp++; if (o_count !== 4'd5 || sym_if.symbol !== SYM_4) begin n_bad++; $display("FAIL rs_pre_state: got %0d/%0d want 5/%0d", o_count, sym_if.symbol, SYM_4); end
      feed("C");
      n_cmp++; if (o_count !== 4'd1) begin n_bad++; $display("FAIL rs_count: got %0d want 1", o_count); end
      n_cmp++; if (sym_if.symbol !== SYM_RESET) begin n_bad++; $display("FAIL rs_symbol: got %0d want %0d", sym_if.symbol, SYM_RESET); end
      n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL rs_overflow: got %b want 0", o_overflow); end
      feed(" ");
      n_cmp++; if (o_count !== 4'd1) begin n_bad++; $display("FAIL rs_sep_drop: got %0d want 1", o_count); end
      feed("5");
      @(negedge i_clk);
      i_data = 8'h63;
      i_data_valid = 1'b1;
      @(negedge i_clk);
      i_data_valid = 1'b0;
      sym_if.ready = 1'b1;
      @(negedge i_clk);
      sym_if.ready = 1'b0;
      n_cmp++; if (o_count !== 4'd1 || sym_if.symbol !== SYM_RESET) begin n_bad++; $display("FAIL rs_pop_ignored: got %0d/%0d want 1/%0d", o_count, sym_if.symbol, SYM_RESET); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      sym_if.ready = 1'b0;
      feed("123");
      n_cmp++; if (o_count !== 4'd3) begin n_bad++; $display("FAIL mr_pre_count: got %0d want 3", o_count); end
      @(negedge i_clk);
      i_data = 8'h36;
      i_data_valid = 1'b1;
      @(negedge i_clk);
      i_data_valid = 1'b0;
      i_rst = 1'b1;
      #1;
      n_cmp++; if (sym_if.valid !== 1'b0 || o_count !== 4'd0 || sym_if.symbol !== SYM_INVALID) begin n_bad++; $display("FAIL mr_state: got %b/%0d/%0d want 0/0/%0d", sym_if.valid, o_count, sym_if.symbol, SYM_INVALID); end
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (2) @(negedge i_clk);
      n_cmp++; if (o_count !== 4'd0) begin n_bad++; $display("FAIL mr_decode_lost: got %0d want 0", o_count); end
      i_data = 8'h34;
      i_data_valid = 1'b1;
      @(negedge i_clk);
      i_data_valid = 1'b0;
      n_cmp++; if (sym_if.valid !== 1'b0) begin n_bad++; $display("FAIL mr_latency_early: got %b want 0", sym_if.valid); end
      @(negedge i_clk);
      n_cmp++; if (sym_if.valid !== 1'b1 || sym_if.symbol !== SYM_4) begin n_bad++; $display("FAIL mr_latency: got %b/%0d want 1/%0d", sym_if.valid, sym_if.symbol, SYM_4); end
   endtask

   initial begin
      sym_if.ready = 1'b0;
      test_reset();
      test_stream();
      test_sep_filter();
      test_overflow();
      test_full_push_pop();
      test_reset_symbol();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
